// File: rtl/beam_envelope_stage_if.sv
// Stream bundle between the beamformer sum and the envelope stage (input side)
// and between the envelope stage and the readout consumer (output side).
interface beam_envelope_stage_if #(
    parameter int unsigned IN_W  = 36,
    parameter int unsigned OUT_W = 16
) ();
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/beam_envelope_stage.sv
// Envelope stage: |sample| >> SHIFT, saturated to OUT_W, one pipeline register then
// an output FIFO; frames of FRAME_LEN samples with peak and sticky overflow reporting.
module beam_envelope_stage #(
    parameter int unsigned IN_W       = 36,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 12,
    parameter int unsigned FRAME_LEN  = 540,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    beam_envelope_stage_if.slave  bus,
    output logic [OUT_W-1:0]      peak_o,
    output logic                  overflow_o,
    output logic                  frame_done_o,
    output logic                  busy_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FRAME_LEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);
    localparam logic [PtrW:0]   Depth   = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic                 stage_v_q;
    logic [OUT_W-1:0]     stage_data_q;
    logic                 stage_last_q;
    logic [OUT_W:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q;
    logic [CntW-1:0]      in_cnt_q;
    logic [OUT_W-1:0]     max_q, peak_q;
    logic                 ovf_q;

    logic                 in_fire, out_fire, last_in, pop_last;
    logic [IN_W-1:0]      mag, shifted;
    logic                 sat;
    logic [OUT_W-1:0]     s_val;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;
    assign last_in  = in_fire && (in_cnt_q == LastCnt);
    assign pop_last = out_fire && bus.out_last;

    // Negation is done unsigned so the most negative input maps to 2^(IN_W-1).
    always_comb begin
        mag     = bus.in_data[IN_W-1] ? (~bus.in_data + IN_W'(1)) : bus.in_data;
        shifted = mag >> SHIFT;
        sat     = |shifted[IN_W-1:OUT_W];
        s_val   = sat ? '1 : shifted[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start_i)  state_d = StCollect;
            StCollect: if (last_in)  state_d = StDrain;
            StDrain:   if (pop_last) state_d = StDone;
            StDone:                  state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    // Stage register plus FIFO occupancy bounds what may be accepted, so the FIFO never overflows.
    always_comb begin
        bus.in_ready = (state_q == StCollect) &&
                       ((count_q + (PtrW + 1)'(stage_v_q)) < Depth);
        frame_done_o = (state_q == StDone);
        busy_o       = (state_q != StIdle);
    end

    always_comb begin
        bus.out_valid = (count_q != '0);
        bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
        bus.out_last  = bus.out_valid ? mem_q[rd_ptr_q][OUT_W] : 1'b0;
    end

    assign peak_o     = peak_q;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (stage_v_q) begin
            mem_q[wr_ptr_q] <= {stage_last_q, stage_data_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_v_q    <= 1'b0;
            stage_data_q <= '0;
            stage_last_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            stage_v_q <= in_fire;
            if (in_fire) begin
                stage_data_q <= s_val;
                stage_last_q <= (in_cnt_q == LastCnt);
            end
            if (stage_v_q) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (out_fire) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({stage_v_q, out_fire})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q <= '0;
            max_q    <= '0;
            peak_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if ((state_q == StIdle) && start_i) begin
                in_cnt_q <= '0;
                max_q    <= '0;
                ovf_q    <= 1'b0;
            end else if (in_fire) begin
                in_cnt_q <= last_in ? '0 : in_cnt_q + CntW'(1);
                if (sat) begin
                    ovf_q <= 1'b1;
                end
                if (s_val > max_q) begin
                    max_q <= s_val;
                end
            end
            if (state_q == StDone) begin
                peak_q <= max_q;
            end
        end
    end
endmodule

// File: tb/tb_beam_envelope_stage.sv
// Directed-plus-random bench for beam_envelope_stage against a transaction-level model
// (expected-output queue with arrival times, frame/peak/overflow bookkeeping).
module tb_beam_envelope_stage;
    localparam int unsigned IN_W      = 36;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned FRAME_LEN = 540;
    localparam int unsigned DEPTH     = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [OUT_W-1:0] peak;
    logic             overflow, frame_done, busy;

    beam_envelope_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    beam_envelope_stage dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .bus          (bus),
        .peak_o       (peak),
        .overflow_o   (overflow),
        .frame_done_o (frame_done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     last;
        longint t;
    } item_t;

    item_t       q[$];
    bit          m_active, m_done, m_ovf;
    int          m_acc;
    longint      m_max, m_peak;
    longint      cyc = 0;
    int          n_cmp = 0, n_err = 0;
    logic [35:0] fdata [FRAME_LEN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Unsaturated |d| >> 12 from plain signed arithmetic.
    function automatic longint ref_raw(input logic [35:0] d);
        longint v;
        v = longint'($signed(d));
        if (v < 0) v = -v;
        return v >> 12;
    endfunction

    task automatic model_clear();
        q.delete();
        m_active = 0; m_done = 0; m_ovf = 0; m_acc = 0; m_max = 0; m_peak = 0;
    endtask

    task automatic cycle(input bit iv, input logic [35:0] d, input bit ordy, input bit st,
                         output bit acc);
        bit     inf, outf, done_next, was_active, exp_v;
        longint raw, sv;
        item_t  it;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        start         = st;
        #1;
        check("in_ready", bus.in_ready,
              m_active && (m_acc < FRAME_LEN) && (q.size() < DEPTH));
        exp_v = (q.size() > 0) && (q[0].t <= cyc);
        check("out_valid", bus.out_valid, exp_v);
        if (exp_v) begin
            check("out_data", bus.out_data, q[0].data);
            check("out_last", bus.out_last, q[0].last);
        end
        check("busy", busy, m_active);
        check("frame_done", frame_done, m_done);
        check("overflow", overflow, m_ovf);
        check("peak", peak, m_peak);

        was_active = m_active;
        inf        = iv && bus.in_ready;
        outf       = bus.out_valid && ordy;
        done_next  = 0;
        if (outf && q.size() > 0) begin
            done_next = q[0].last;
            void'(q.pop_front());
        end
        if (inf) begin
            raw     = ref_raw(d);
            sv      = (raw > 65535) ? 65535 : raw;
            it.data = sv;
            it.last = (m_acc == FRAME_LEN - 1);
            it.t    = cyc + 2;
            q.push_back(it);
            m_acc++;
            if (raw > 65535) m_ovf = 1;
            if (sv > m_max) m_max = sv;
        end
        if (m_done) begin
            m_active = 0;
            m_peak   = m_max;
        end
        if (st && !was_active) begin
            m_active = 1; m_ovf = 0; m_acc = 0; m_max = 0;
        end
        m_done = done_next;
        acc    = inf;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_peak", peak, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        model_clear();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        start         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 1 randomizes in_valid; rdy_mode: 0 always ready, 1 random, 2 stalled for 40 cycles.
    task automatic run_frame(input int mode, input int rdy_mode, input int abort_at);
        int k = 0;
        int budget = 0;
        bit acc, iv, ordy, st;
        cycle(1'b0, '0, 1'b1, 1'b1, acc);
        while (budget < 6000) begin
            iv = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (rdy_mode)
                0:       ordy = 1'b1;
                1:       ordy = 1'($urandom_range(0, 1));
                default: ordy = (budget >= 40);
            endcase
            if (rdy_mode == 2 && budget == 40) check("fill_count", k, DEPTH);
            st = (k == 100);
            cycle(iv, (k < FRAME_LEN) ? fdata[k] : '0, ordy, st, acc);
            if (acc) k++;
            if (abort_at > 0 && k == abort_at) begin
                do_reset();
                return;
            end
            if (!m_active) break;
            budget++;
        end
        if (budget >= 6000) begin
            n_cmp++;
            n_err++;
            $error("FAIL frame_timeout: observed %0d samples expected %0d", k, FRAME_LEN);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_clear();

        do_reset();
        idle(3);

        for (int k = 0; k < FRAME_LEN; k++) fdata[k] = 36'(k) << 12;
        run_frame(0, 0, 0);
        @(negedge clk); #1;
        check("peak_ramp", peak, 539);
        check("ovf_ramp", overflow, 0);

        for (int k = 0; k < FRAME_LEN; k++)
            fdata[k] = 36'($signed({$urandom, $urandom}) >>> $urandom_range(0, 40));
        fdata[3] = -(36'(5) << 12);
        fdata[7] = 36'h8_0000_0000;
        run_frame(1, 1, 0);
        @(negedge clk); #1;
        check("ovf_sticky", overflow, 1);
        idle(5);

        for (int k = 0; k < FRAME_LEN; k++) fdata[k] = 36'(k) << 12;
        run_frame(0, 2, 0);

        run_frame(0, 0, 200);
        idle(4);
        run_frame(0, 0, 0);
        @(negedge clk); #1;
        check("peak_fresh", peak, 539);
        check("busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
